cache_bus1_arbiter: RTL and testbench
=====================================

Name: cache_bus1_arbiter

Overview:
- Shares the CPU-to-cache bus 1 (A1/D1/C1) between two requesters, e.g. two core models or a core plus a dump/verify agent.
- Each requester issues a flat request: command, 18-bit byte address and 32-bit write data.
- The block arbitrates round-robin and sequences the bus-1 transaction: two-cycle command/address phase, bus turnaround, wait for the cache response, read-beat capture, hand-back NOP.
- Sits between requesters and the cache model, replacing ad-hoc per-task bus driving.

Parameters:
- ADDR_W, 18, byte address width (CACHE_ADDR_SIZE).
- OFFSET_W, 4, offset bits sent in the second address cycle (CACHE_OFFSET_SIZE).
- A1_W, 14, A1 bus width (ADDR1_BUS_SIZE).
- D1_W, 16, D1 bus width (DATA1_BUS_SIZE).
- C1_W, 3, C1 bus width (CTR1_BUS_SIZE).
- TIMEOUT, 1023, response watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK, input, 1, sole clock; all state updates on posedge.
- RESET_N, input, 1, asynchronous active-low reset.
- REQ, input, 2, per-requester request, held until its DONE.
- CMD0 / CMD1, input, 3 each, C1 command: 1 R8, 2 R16, 3 R32, 4 INV, 5 W8, 6 W16, 7 W32.
- ADDR0 / ADDR1, input, ADDR_W each, byte address.
- WDATA0 / WDATA1, input, 32 each, write data; low bits used for W8/W16.
- DONE, output, 2, one-cycle completion pulse per requester.
- ERR, output, 2, one-cycle timeout pulse per requester; constant 0 without the optional feature.
- RDATA, output, 32, read result; valid while any DONE bit is high.
- GNT_ID, output, 1, index of the current or last granted requester.
- BUSY, output, 1, high whenever the FSM is not IDLE.
- A1, output, A1_W, bus-1 address.
- D1, inout, D1_W, bus-1 data; high-Z when not driven.
- C1, inout, C1_W, bus-1 command/response; high-Z when not driven.

Behaviour:
- Reset values (async on RESET_N low):
  - FSM enters IDLE; DONE=0, ERR=0, RDATA=0, GNT_ID=1 (so requester 0 wins first), BUSY=0, A1=0.
  - C1/D1 drive enables are off (Z).
  - Reset mid-transaction abandons the transaction with no DONE. The cache owns recovery.
- Arbitration (IDLE only):
  - A single REQ bit is granted.
  - If both are set, the requester not equal to the last GNT_ID wins.
  - Command, address and data are latched at grant; requester inputs are ignored afterwards.
  - CMD=0 is treated as a no-op: DONE next cycle, bus untouched.
- States:
  - IDLE.
  - CMDA (1 cycle): C1=cmd, A1=addr[ADDR_W-1:OFFSET_W]. D1=wdata[15:0] for writes, else Z.
  - ADDR (1 cycle): C1=cmd, A1=addr[OFFSET_W-1:0] zero-extended. D1=wdata[31:16] for W32, wdata[15:0] for W8/W16, else Z.
  - WAIT: C1 and D1 released to Z; remain until C1===7 is sampled.
    - On that edge, reads latch D1 into RDATA[15:0]; R8 zero-extends bits [7:0], R16 zero-extends [15:0].
    - R32 then goes to RD1; all other commands go to REL.
  - RD1 (1 cycle): latch D1 into RDATA[31:16]; go to REL.
  - REL (1 cycle): drive C1=0 (NOP); D1 stays Z; pulse DONE[gnt]; go to IDLE.
- Latency:
  - Grant to DONE = 4 + W cycles for non-R32, 5 + W for R32, where W = WAIT cycles before the response.
  - At most one transaction in flight; the next grant comes no earlier than the cycle after REL.
- Bus contention:
  - C1 is driven only in CMDA, ADDR and REL; D1 only in CMDA and ADDR for writes.
  - C1 values other than 7 in WAIT, including X or Z, are ignored.
- REQ dropped before DONE is ignored; the transaction completes and DONE still pulses.
- REQ still high after DONE is treated as a new request.

Optional Feature:
- Macro: CACHE_BUS1_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter saturates at TIMEOUT.
  - On reaching it, go to REL, pulse ERR[gnt] instead of DONE, and set RDATA=0.
  - The counter clears on entry to WAIT.
- Not defined: no counter; WAIT is unbounded; ERR is tied to 0.

Test Plan:
- Single R8: REQ0 with CMD0=1, ADDR0=0x00123. Expect A1=0x0012 then A1=0x3, C1=1 for both cycles. Cache responds with C1=7, D1=0x00AB after 6 cycles. Expect RDATA=0x000000AB, DONE=2'b01, total 10 cycles.
- W32: REQ1 with CMD1=7, ADDR1=0x02000, WDATA1=0xDEADBEEF. Expect D1=0xBEEF with A1=0x0200, then D1=0xDEAD with A1=0x0. Then Z until C1=7, then C1=0 for one cycle, then DONE=2'b10.
- R32 two-beat capture: response beats D1=0x5678 then 0x1234. Expect RDATA=0x12345678.
- Contention: REQ=2'b11 held for 3 transactions. Expect grant order 0, 1, 0 and no C1/D1 overlap with the cache model (no X on the bus).
- Reset: assert RESET_N=0 during WAIT. Expect immediate Z on C1/D1, BUSY=0, no DONE. After release, a fresh R16 completes normally.
- With CACHE_BUS1_TIMEOUT_EN and TIMEOUT=8: cache never responds. Expect ERR pulse on the 8th WAIT cycle followed by REL, and DONE stays 0.

Source files
------------

// File: rtl/cache_bus1_arbiter.sv
// Round-robin arbiter and bus-1 (A1/D1/C1) sequencer for two requesters.
// Optional response watchdog: define CACHE_BUS1_TIMEOUT_EN (adds TIMEOUT).
//
// Ports:
//   CLK, RESET_N          clock, async active-low reset
//   REQ[1:0]              per-requester request, held until DONE
//   CMD0/1, ADDR0/1       C1 command and byte address per requester
//   WDATA0/1              write data per requester
//   DONE[1:0], ERR[1:0]   one-cycle completion / timeout pulses
//   RDATA                 read result, valid while a DONE bit is high
//   GNT_ID, BUSY          current/last grant, FSM not idle
//   A1, D1, C1            bus-1 address, data (inout), command (inout)
module cache_bus1_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int OFFSET_W = 4,
  parameter int A1_W     = 14,
  parameter int D1_W     = 16,
  parameter int C1_W     = 3
`ifdef CACHE_BUS1_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 1023
`endif
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [1:0]        REQ,
  input  logic [2:0]        CMD0,
  input  logic [2:0]        CMD1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [31:0]       WDATA0,
  input  logic [31:0]       WDATA1,
  output logic [1:0]        DONE,
  output logic [1:0]        ERR,
  output logic [31:0]       RDATA,
  output logic              GNT_ID,
  output logic              BUSY,
  output logic [A1_W-1:0]   A1,
  inout  wire  [D1_W-1:0]   D1,
  inout  wire  [C1_W-1:0]   C1
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMDA, S_ADDR, S_WAIT, S_RD1, S_REL
  } state_t;

  localparam logic [2:0] C_R8  = 3'd1;
  localparam logic [2:0] C_R32 = 3'd3;
  localparam logic [2:0] C_W32 = 3'd7;

  state_t              state_q, state_n;
  logic                gnt_q;
  logic [2:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [1:0]          done_q;

  logic                gid;
  logic [2:0]          cmd_sel;
  logic [ADDR_W-1:0]   addr_sel;
  logic [31:0]         wd_sel;
  logic                is_wr, is_rd;
  logic                resp;
  logic                to_hit;
  logic                take, nop_go;
  logic                cap_lo, cap_hi, fin;
  logic                c1_oe, d1_oe;
  logic [C1_W-1:0]     c1_o;
  logic [D1_W-1:0]     d1_o;
  logic [A1_W-1:0]     a1_o;

  // With both requesting, the one not served last wins.
  assign gid      = REQ[1] & (~REQ[0] | ~gnt_q);
  assign cmd_sel  = gid ? CMD1   : CMD0;
  assign addr_sel = gid ? ADDR1  : ADDR0;
  assign wd_sel   = gid ? WDATA1 : WDATA0;
  assign take     = (state_q == S_IDLE) && (|REQ);
  assign nop_go   = take && (cmd_sel == 3'd0);

  assign is_wr = cmd_q[2] & (|cmd_q[1:0]);
  assign is_rd = ~cmd_q[2] & (|cmd_q[1:0]);
  // Anything but 7 (including X/Z) is not a response.
  assign resp  = (C1 == C1_W'(7));

`ifdef CACHE_BUS1_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt_q;
  logic [1:0]    err_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wcnt_q <= '0;
    end else if (state_q != S_WAIT) begin
      wcnt_q <= '0;
    end else if (wcnt_q != CW'(TIMEOUT)) begin
      wcnt_q <= wcnt_q + CW'(1);
    end
  end

  assign to_hit = (state_q == S_WAIT) && !resp &&
                  (wcnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_q <= '0;
    end else begin
      err_q <= '0;
      if (to_hit) err_q[gnt_q] <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign to_hit = 1'b0;
  assign ERR    = '0;
`endif

  always_comb begin
    state_n = state_q;
    c1_oe   = 1'b0;
    c1_o    = '0;
    d1_oe   = 1'b0;
    d1_o    = '0;
    a1_o    = '0;
    cap_lo  = 1'b0;
    cap_hi  = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (take && !nop_go) state_n = S_CMDA;
      end
      S_CMDA: begin
        c1_oe   = 1'b1;
        c1_o    = C1_W'(cmd_q);
        a1_o    = A1_W'(addr_q[ADDR_W-1:OFFSET_W]);
        d1_oe   = is_wr;
        d1_o    = D1_W'(wdata_q[15:0]);
        state_n = S_ADDR;
      end
      S_ADDR: begin
        c1_oe   = 1'b1;
        c1_o    = C1_W'(cmd_q);
        a1_o    = A1_W'(addr_q[OFFSET_W-1:0]);
        d1_oe   = is_wr;
        d1_o    = (cmd_q == C_W32) ?
                  D1_W'(wdata_q[31:16]) :
                  D1_W'(wdata_q[15:0]);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (resp) begin
          cap_lo = is_rd;
          if (cmd_q == C_R32) begin
            state_n = S_RD1;
          end else begin
            state_n = S_REL;
            fin     = 1'b1;
          end
        end else if (to_hit) begin
          state_n = S_REL;
        end
      end
      S_RD1: begin
        cap_hi  = 1'b1;
        fin     = 1'b1;
        state_n = S_REL;
      end
      S_REL: begin
        c1_oe   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b1;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_n;
      done_q  <= '0;
      if (take) begin
        gnt_q   <= gid;
        cmd_q   <= cmd_sel;
        addr_q  <= addr_sel;
        wdata_q <= wd_sel;
      end
      if (nop_go) done_q[gid] <= 1'b1;
      if (fin) done_q[gnt_q] <= 1'b1;
      if (cap_lo) begin
        rdata_q <= (cmd_q == C_R8) ?
                   {24'd0, D1[7:0]} :
                   {16'd0, D1[15:0]};
      end
      if (cap_hi) rdata_q[31:16] <= D1[15:0];
      if (to_hit) rdata_q <= '0;
    end
  end

  assign C1     = c1_oe ? c1_o : 'z;
  assign D1     = d1_oe ? d1_o : 'z;
  assign A1     = a1_o;
  assign DONE   = done_q;
  assign RDATA  = rdata_q;
  assign GNT_ID = gnt_q;
  assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_bus1_arbiter.sv
// Bench for cache_bus1_arbiter: directed plus random bus-1 transactions
// against a cache model and a transaction-level reference model.
module tb_cache_bus1_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic [1:0]  REQ;
  logic [2:0]  CMD0, CMD1;
  logic [17:0] ADDR0, ADDR1;
  logic [31:0] WDATA0, WDATA1;
  logic [1:0]  DONE, ERR;
  logic [31:0] RDATA;
  logic        GNT_ID, BUSY;
  logic [13:0] A1;
  // Released bus lines read back as 0.
  tri0  [15:0] D1;
  tri0  [2:0]  C1;

  logic        c_oe, d_oe;
  logic [2:0]  c_c1;
  logic [15:0] c_d1;
  assign C1 = c_oe ? c_c1 : 'z;
  assign D1 = d_oe ? c_d1 : 'z;

  int checks = 0;
  int errors = 0;

  // Reference state: last winner and last read result.
  logic        last;
  logic [31:0] rdata_m;

  cache_bus1_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ),
    .CMD0(CMD0), .CMD1(CMD1),
    .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
    .GNT_ID(GNT_ID), .BUSY(BUSY),
    .A1(A1), .D1(D1), .C1(C1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    CMD0   = 3'($urandom);
    CMD1   = 3'($urandom);
    ADDR0  = 18'($urandom);
    ADDR1  = 18'($urandom);
    WDATA0 = $urandom;
    WDATA1 = $urandom;
  endtask

  // Starts at a negedge with the arbiter idle; ends at the
  // negedge of the idle cycle after completion with REQ low.
  task automatic txn(input logic [1:0] req, input int w,
                     input logic [15:0] b0, input logic [15:0] b1);
    logic        win;
    logic [2:0]  cmd;
    logic [17:0] ad;
    logic [31:0] wd;
    logic        wr;
    logic [15:0] d1e;
    win = (req == 2'b11) ? ~last : req[1];
    cmd = win ? CMD1 : CMD0;
    ad  = win ? ADDR1 : ADDR0;
    wd  = win ? WDATA1 : WDATA0;
    wr  = (cmd >= 3'd5);
    REQ = req;
    @(posedge CLK);
    #1;
    scramble();
    last = win;
    @(negedge CLK);
    chk("gnt", GNT_ID, win);
    if (cmd == 3'd0) begin
      chk("nop_done", DONE, 2'b01 << win);
      chk("nop_busy", BUSY, 0);
      chk("nop_c1", C1, 0);
      REQ = 2'b00;
      @(negedge CLK);
      chk("nop_after", DONE, 0);
      return;
    end
    chk("cmda_busy", BUSY, 1);
    chk("cmda_c1", C1, cmd);
    chk("cmda_a1", A1, ad[17:4]);
    chk("cmda_d1", D1, wr ? wd[15:0] : 16'h0);
    chk("cmda_done", DONE, 0);
    @(negedge CLK);
    d1e = !wr ? 16'h0 :
          (cmd == 3'd7) ? wd[31:16] : wd[15:0];
    chk("addr_c1", C1, cmd);
    chk("addr_a1", A1, {10'd0, ad[3:0]});
    chk("addr_d1", D1, d1e);
    for (int i = 0; i <= w; i++) begin
      @(negedge CLK);
      c_oe = 1'b0;
      d_oe = 1'b0;
      #1;
      chk("wait_c1", C1, 0);
      chk("wait_d1", D1, 0);
      chk("wait_done", DONE, 0);
      chk("wait_busy", BUSY, 1);
      if (i < w) begin
        // Non-response noise on the bus must be ignored.
        if ($urandom_range(1, 0) == 1) begin
          c_oe = 1'b1;
          c_c1 = 3'($urandom_range(6, 0));
          d_oe = 1'b1;
          c_d1 = 16'($urandom);
        end
      end else begin
        c_oe = 1'b1;
        c_c1 = 3'd7;
        d_oe = 1'b1;
        c_d1 = b0;
      end
    end
    @(posedge CLK);
    #1;
    c_oe = 1'b0;
    d_oe = 1'b0;
    if (cmd == 3'd3) begin
      d_oe = 1'b1;
      c_d1 = b1;
      @(negedge CLK);
      chk("rd1_done", DONE, 0);
      chk("rd1_c1", C1, 0);
      @(posedge CLK);
      #1;
      d_oe = 1'b0;
    end
    @(negedge CLK);
    case (cmd)
      3'd1:    rdata_m = {24'd0, b0[7:0]};
      3'd2:    rdata_m = {16'd0, b0};
      3'd3:    rdata_m = {b1, b0};
      default: rdata_m = rdata_m;
    endcase
    chk("rel_c1", C1, 0);
    chk("rel_d1", D1, 0);
    chk("done", DONE, 2'b01 << win);
    chk("err", ERR, 0);
    chk("rdata", RDATA, rdata_m);
    chk("rel_busy", BUSY, 1);
    @(negedge CLK);
    REQ = 2'b00;
    chk("idle_done", DONE, 0);
    chk("idle_busy", BUSY, 0);
  endtask

  initial begin
    RESET_N = 1'b0;
    REQ     = 2'b00;
    CMD0    = 3'd0;
    CMD1    = 3'd0;
    ADDR0   = '0;
    ADDR1   = '0;
    WDATA0  = '0;
    WDATA1  = '0;
    c_oe    = 1'b0;
    d_oe    = 1'b0;
    c_c1    = 3'd0;
    c_d1    = 16'd0;
    last    = 1'b1;
    rdata_m = '0;
    #12;
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_gnt", GNT_ID, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_a1", A1, 0);
    chk("rst_c1", C1, 0);
    chk("rst_d1", D1, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Single R8.
    CMD0  = 3'd1;
    ADDR0 = 18'h00123;
    txn(2'b01, 6, 16'h00AB, 16'h0);
    chk("tp_r8", RDATA, 32'h0000_00AB);

    // R32 two-beat capture.
    CMD0  = 3'd3;
    ADDR0 = 18'h0_4A5C;
    txn(2'b01, 2, 16'h5678, 16'h1234);
    chk("tp_r32", RDATA, 32'h1234_5678);

    // W32 from requester 1.
    CMD1   = 3'd7;
    ADDR1  = 18'h02000;
    WDATA1 = 32'hDEAD_BEEF;
    txn(2'b10, 3, 16'h0, 16'h0);

    // Contention: order alternates 0, 1, 0.
    for (int k = 0; k < 3; k++) begin
      CMD0 = 3'($urandom_range(7, 1));
      CMD1 = 3'($urandom_range(7, 1));
      txn(2'b11, k + 1, 16'($urandom), 16'($urandom));
      chk("rr_order", GNT_ID, k[0]);
    end

    // No-op and invalidate.
    CMD0 = 3'd0;
    txn(2'b01, 0, 16'h0, 16'h0);
    CMD1  = 3'd4;
    ADDR1 = 18'h3_FFFF;
    txn(2'b10, 0, 16'hFFFF, 16'h0);

    // Reset during WAIT abandons the transaction.
    CMD0  = 3'd2;
    ADDR0 = 18'h0_0040;
    REQ   = 2'b01;
    repeat (4) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_c1", C1, 0);
    chk("mid_rst_d1", D1, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_gnt", GNT_ID, 1);
    REQ = 2'b00;
    @(negedge CLK);
    chk("mid_rst_done2", DONE, 0);
    RESET_N = 1'b1;
    last    = 1'b1;
    rdata_m = '0;
    CMD0  = 3'd2;
    ADDR0 = 18'h0_0040;
    txn(2'b01, 1, 16'hC0DE, 16'h0);
    chk("post_rst_r16", RDATA, 32'h0000_C0DE);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      scramble();
      txn(2'($urandom_range(3, 1)), $urandom_range(5, 0),
          16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
